// File: rtl/fast_vram_ctrl_if.sv
// Requester-side handshake bundle for fast_vram_ctrl.
//   slave  : controller view (requests in, acks and captured read data out)
//   master : requester view (video fetch port and CPU port)
interface fast_vram_ctrl_if;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          VID_REQ;
  logic [AW-1:0] VID_ADDR;
  logic          VID_ACK;
  logic [DW-1:0] VID_DATA;

  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_WDATA;
  logic          CPU_ACK;
  logic [DW-1:0] CPU_RDATA;

  modport slave (
    input  VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    output VID_ACK, VID_DATA, CPU_ACK, CPU_RDATA
  );

  modport master (
    output VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA,
    input  VID_ACK, VID_DATA, CPU_ACK, CPU_RDATA
  );
endinterface

// File: rtl/fast_vram_ctrl.sv
// Access controller for the 2K x 16 fast VRAM pair (two 2K x 8 async SRAMs).
// Arbitrates video reads and CPU reads/writes, and sequences the SRAM strobes.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : request/ack handshake for video and CPU ports (slave modport)
//   ADDR, DATA : SRAM address and bidirectional data ([15:8] upper, [7:0] lower chip)
//   nCE/nOE/nWE: SRAM strobes, active low
// All outputs, including the DATA drive enable, come straight from flops.
module fast_vram_ctrl #(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  fast_vram_ctrl_if.slave        bus,
  output logic [10:0]            ADDR,
  inout  wire  [15:0]            DATA,
  output logic                   nCE,
  output logic                   nOE,
  output logic                   nWE
);
  localparam int unsigned AW      = 11;
  localparam int unsigned DW      = 16;
  localparam int unsigned MAX_CNT = (READ_WAIT > WE_CYCLES) ? READ_WAIT : WE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WSETUP, ST_WPULSE, ST_WHOLD} state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           sel_cpu_q, sel_cpu_d;     // current access belongs to the CPU
  logic           prio_cpu_q, prio_cpu_d;   // CPU wins the next tie
  logic           nce_q, nce_d, noe_q, noe_d, nwe_q, nwe_d;
  logic           drive_q, drive_d;
  logic           vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d;
  logic [DW-1:0]  vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d;
  logic           grant_cpu;

  assign ADDR          = addr_q;
  assign nCE           = nce_q;
  assign nOE           = noe_q;
  assign nWE           = nwe_q;
  assign DATA          = drive_q ? wdata_q : 'z;
  assign bus.VID_ACK   = vid_ack_q;
  assign bus.VID_DATA  = vid_data_q;
  assign bus.CPU_ACK   = cpu_ack_q;
  assign bus.CPU_RDATA = cpu_rdata_q;

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_cpu_d   = sel_cpu_q;
    prio_cpu_d  = prio_cpu_q;
    nce_d       = nce_q;
    noe_d       = noe_q;
    nwe_d       = nwe_q;
    drive_d     = drive_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    grant_cpu   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        nce_d   = 1'b1;
        noe_d   = 1'b1;
        nwe_d   = 1'b1;
        drive_d = 1'b0;
        if (bus.VID_REQ || bus.CPU_REQ) begin
          // On a tie the flag alternates grants between the two ports.
          grant_cpu  = bus.CPU_REQ && (!bus.VID_REQ || prio_cpu_q);
          sel_cpu_d  = grant_cpu;
          prio_cpu_d = !grant_cpu;
          cnt_d      = '0;
          nce_d      = 1'b0;
          if (grant_cpu && bus.CPU_WE) begin
            addr_d  = bus.CPU_ADDR;
            wdata_d = bus.CPU_WDATA;
            drive_d = 1'b1;
            state_d = ST_WSETUP;
          end else begin
            addr_d  = grant_cpu ? bus.CPU_ADDR : bus.VID_ADDR;
            noe_d   = 1'b0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_W'(READ_WAIT)) begin
          nce_d   = 1'b1;
          noe_d   = 1'b1;
          state_d = ST_IDLE;
          if (sel_cpu_q) begin
            cpu_rdata_d = DATA;
            cpu_ack_d   = 1'b1;
          end else begin
            vid_data_d  = DATA;
            vid_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WSETUP: begin
        nwe_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_WPULSE;
      end
      ST_WPULSE: begin
        if (cnt_q == CNT_W'(WE_CYCLES - 1)) begin
          // Data stays driven one more cycle for SRAM hold time.
          nwe_d     = 1'b1;
          nce_d     = 1'b1;
          cpu_ack_d = 1'b1;
          state_d   = ST_WHOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WHOLD: begin
        drive_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_cpu_q   <= 1'b0;
      prio_cpu_q  <= 1'b0;
      nce_q       <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      drive_q     <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_cpu_q   <= sel_cpu_d;
      prio_cpu_q  <= prio_cpu_d;
      nce_q       <= nce_d;
      noe_q       <= noe_d;
      nwe_q       <= nwe_d;
      drive_q     <= drive_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // SRAM bus safety properties.
  a_no_drive_while_oe: assert property (@(posedge CLK) disable iff (RESET) !(drive_q && !noe_q));
  a_no_oe_and_we:      assert property (@(posedge CLK) disable iff (RESET) !(!noe_q && !nwe_q));
  a_addr_stable:       assert property (@(posedge CLK) disable iff (RESET)
                                        (!nce_q && $past(!nce_q)) |-> $stable(addr_q));
  a_idle_ce_high:      assert property (@(posedge CLK) disable iff (RESET)
                                        (state_q == ST_IDLE) |-> nce_q);
endmodule

// File: tb/tb_fast_vram_ctrl.sv
// Directed bench for fast_vram_ctrl: instance 0 uses READ_WAIT=1/WE_CYCLES=1,
// instance 1 uses READ_WAIT=3/WE_CYCLES=2. Each has its own SRAM model.
module tb_fast_vram_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vid_req [2];
  logic [10:0] vid_addr [2];
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [10:0] cpu_addr [2];
  logic [15:0] cpu_wdata [2];
  logic        vid_ack [2];
  logic [15:0] vid_data [2];
  logic        cpu_ack [2];
  logic [15:0] cpu_rdata [2];
  logic [10:0] ram_addr [2];
  logic [15:0] ram_data [2];
  logic        nce [2];
  logic        noe [2];
  logic        nwe [2];
  logic        drv [2];

  logic [15:0] mem [2][2048];
  logic [15:0] ref_mem [2048];

  logic        pl_en;
  bit          pl_g;
  logic [10:0] pl_a;
  logic [15:0] pl_d;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int unsigned RW = (g == 0) ? 1 : 3;
    localparam int unsigned WC = (g == 0) ? 1 : 2;
    fast_vram_ctrl_if bus ();
    wire  [15:0] data;
    logic [10:0] a;
    logic        ce, oe, we;

    assign bus.VID_REQ   = vid_req[g];
    assign bus.VID_ADDR  = vid_addr[g];
    assign bus.CPU_REQ   = cpu_req[g];
    assign bus.CPU_WE    = cpu_we[g];
    assign bus.CPU_ADDR  = cpu_addr[g];
    assign bus.CPU_WDATA = cpu_wdata[g];
    assign vid_ack[g]    = bus.VID_ACK;
    assign vid_data[g]   = bus.VID_DATA;
    assign cpu_ack[g]    = bus.CPU_ACK;
    assign cpu_rdata[g]  = bus.CPU_RDATA;

    fast_vram_ctrl #(.READ_WAIT(RW), .WE_CYCLES(WC)) dut (
      .CLK(clk), .RESET(rst), .bus(bus),
      .ADDR(a), .DATA(data), .nCE(ce), .nOE(oe), .nWE(we)
    );

    // Asynchronous SRAM read: drives the bus while selected and output-enabled.
    assign data        = (!ce && !oe) ? mem[g][a] : 'z;
    assign ram_addr[g] = a;
    assign ram_data[g] = data;
    assign nce[g]      = ce;
    assign noe[g]      = oe;
    assign nwe[g]      = we;
    assign drv[g]      = dut.drive_q;
  end

  // SRAM write (sampled while nCE and nWE are low) and bench preload port.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!nce[i] && !nwe[i]) mem[i[0]][ram_addr[i]] <= ram_data[i];
    end
    if (pl_en) mem[pl_g][pl_a] <= pl_d;
  end

  function automatic int rd_wait(input bit g);
    return g ? 3 : 1;
  endfunction

  function automatic int we_cycles(input bit g);
    return g ? 2 : 1;
  endfunction

  // Bus monitor: invariants, ACK width, strobe run lengths.
  int viol [2];
  int noe_run [2];
  int nwe_run [2];
  int last_noe [2];
  int last_nwe [2];
  bit p_nce [2];
  bit p_vack [2];
  bit p_cack [2];
  bit [10:0] p_addr [2];

  task automatic mon(input bit g);
    if (rst) begin
      noe_run[g] <= 0;
      nwe_run[g] <= 0;
    end else begin
      if (drv[g] && !noe[g]) begin
        viol[g] <= viol[g] + 1;
        $display("FAIL inv_drive inst%0d t=%0t: DATA driven with nOE=0", g, $time);
      end
      if (!noe[g] && !nwe[g]) begin
        viol[g] <= viol[g] + 1;
        $display("FAIL inv_oe_we inst%0d t=%0t: nOE and nWE both low", g, $time);
      end
      if (!nce[g] && p_nce[g] && ram_addr[g] != p_addr[g]) begin
        viol[g] <= viol[g] + 1;
        $display("FAIL inv_addr inst%0d t=%0t: ADDR %h -> %h while nCE low", g, $time, p_addr[g], ram_addr[g]);
      end
      if ((vid_ack[g] && p_vack[g]) || (cpu_ack[g] && p_cack[g])) begin
        viol[g] <= viol[g] + 1;
        $display("FAIL ack_width inst%0d t=%0t: ACK high 2 cycles, required 1", g, $time);
      end
      if (!noe[g]) noe_run[g] <= noe_run[g] + 1;
      else if (noe_run[g] != 0) begin
        last_noe[g] <= noe_run[g];
        noe_run[g]  <= 0;
        if (noe_run[g] != rd_wait(g) + 1) begin
          viol[g] <= viol[g] + 1;
          $display("FAIL noe_len inst%0d: got %0d cycles, required %0d", g, noe_run[g], rd_wait(g) + 1);
        end
      end
      if (!nwe[g]) nwe_run[g] <= nwe_run[g] + 1;
      else if (nwe_run[g] != 0) begin
        last_nwe[g] <= nwe_run[g];
        nwe_run[g]  <= 0;
        if (nwe_run[g] != we_cycles(g)) begin
          viol[g] <= viol[g] + 1;
          $display("FAIL nwe_len inst%0d: got %0d cycles, required %0d", g, nwe_run[g], we_cycles(g));
        end
      end
    end
    p_nce[g]  <= !nce[g];
    p_addr[g] <= ram_addr[g];
    p_vack[g] <= vid_ack[g];
    p_cack[g] <= cpu_ack[g];
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  task automatic preload(input bit g, input logic [10:0] a, input logic [15:0] d);
    pl_g = g; pl_a = a; pl_d = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_vid(input bit g, input logic [10:0] a, output logic [15:0] d, output int lat);
    vid_addr[g] = a;
    vid_req[g]  = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (vid_ack[g]) begin lat = n; break; end
    end
    vid_req[g] = 1'b0;
    d = vid_data[g];
  endtask

  task automatic do_cpu(input bit g, input logic we, input logic [10:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat);
    cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = wd;
    cpu_req[g] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (cpu_ack[g]) begin lat = n; break; end
    end
    cpu_req[g] = 1'b0;
    rd = cpu_rdata[g];
  endtask

  task automatic check_idle_reset(input bit g, input string tag);
    checks++;
    if ({nce[g], noe[g], nwe[g], drv[g], vid_ack[g], cpu_ack[g]} !== 6'b111000) begin
      errors++;
      $display("FAIL %s inst%0d strobes: nCE,nOE,nWE,drive,vack,cack=%b%b%b%b%b%b required 111000",
               tag, g, nce[g], noe[g], nwe[g], drv[g], vid_ack[g], cpu_ack[g]);
    end
    checks++;
    if ({vid_data[g], cpu_rdata[g]} !== 32'h0) begin
      errors++;
      $display("FAIL %s inst%0d capture: VID_DATA=%h CPU_RDATA=%h required 0000", tag, g, vid_data[g], cpu_rdata[g]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_reset(1'b0, "reset");
    check_idle_reset(1'b1, "reset");
    checks++;
    if (ram_addr[0] !== 11'h000) begin
      errors++; $display("FAIL reset_addr: ADDR=%h required 000", ram_addr[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset(1'b0, "reset_idle");
  endtask

  task automatic test_write_read;
    logic [15:0] d; int lat;
    do_cpu(1'b0, 1'b1, 11'h7FF, 16'hA5C3, d, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d required 3", lat); end
    @(negedge clk);
    checks++;
    if ({cpu_ack[0], drv[0], nce[0]} !== 3'b001) begin
      errors++; $display("FAIL wr_release: ack,drive,nCE=%b%b%b required 001", cpu_ack[0], drv[0], nce[0]);
    end
    checks++;
    if (last_nwe[0] !== 1) begin errors++; $display("FAIL wr_nwe_len: got %0d required 1", last_nwe[0]); end
    checks++;
    if (mem[0][11'h7FF] !== 16'hA5C3) begin
      errors++; $display("FAIL wr_ram: RAM[7FF]=%h required a5c3", mem[0][11'h7FF]);
    end
    do_cpu(1'b0, 1'b0, 11'h7FF, 16'h0000, d, lat);
    checks++;
    if (lat !== 3 || d !== 16'hA5C3) begin
      errors++; $display("FAIL rd_cpu: latency %0d data %h required 3 a5c3", lat, d);
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack[0], last_noe[0], vid_data[0]} !== {1'b0, 32'd2, 16'h0000}) begin
      errors++; $display("FAIL rd_cpu_after: ack=%b noe_len=%0d VID_DATA=%h required 0 2 0000",
                         cpu_ack[0], last_noe[0], vid_data[0]);
    end
  endtask

  task automatic test_video_read;
    logic [15:0] d; int lat;
    preload(1'b0, 11'h123, 16'h1234);
    do_vid(1'b0, 11'h123, d, lat);
    checks++;
    if (lat !== 3 || d !== 16'h1234) begin
      errors++; $display("FAIL rd_vid: latency %0d data %h required 3 1234", lat, d);
    end
    @(negedge clk);
    checks++;
    if ({last_noe[0], cpu_rdata[0], vid_data[0]} !== {32'd2, 16'hA5C3, 16'h1234}) begin
      errors++; $display("FAIL rd_vid_hold: noe_len=%0d CPU_RDATA=%h VID_DATA=%h required 2 a5c3 1234",
                         last_noe[0], cpu_rdata[0], vid_data[0]);
    end
  endtask

  // Both ports held high after a fresh reset: grants alternate V,C,... every 3 cycles.
  task automatic test_alternate;
    int cyc, k; bit who;
    preload(1'b0, 11'h010, 16'h1111);
    preload(1'b0, 11'h020, 16'h2222);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vid_addr[0] = 11'h010; cpu_addr[0] = 11'h020; cpu_we[0] = 1'b0;
    vid_req[0] = 1'b1; cpu_req[0] = 1'b1;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (vid_ack[0] || cpu_ack[0]) begin
        who = cpu_ack[0];
        checks++;
        if (who !== k[0] || cyc !== 3 * (k + 1)) begin
          errors++; $display("FAIL alt_grant%0d: port %s at cycle %0d, required %s at cycle %0d",
                             k, who ? "C" : "V", cyc, k[0] ? "C" : "V", 3 * (k + 1));
        end
        checks++;
        if ((who ? cpu_rdata[0] : vid_data[0]) !== (who ? 16'h2222 : 16'h1111)) begin
          errors++; $display("FAIL alt_data%0d: got %h required %h", k,
                             who ? cpu_rdata[0] : vid_data[0], who ? 16'h2222 : 16'h1111);
        end
        k++;
      end
    end
    vid_req[0] = 1'b0; cpu_req[0] = 1'b0;
    checks++;
    if (k !== 8) begin errors++; $display("FAIL alt_count: got %0d grants required 8", k); end
    @(negedge clk);
  endtask

  task automatic test_params;
    logic [15:0] d; int lat;
    do_cpu(1'b1, 1'b1, 11'h000, 16'hFFFF, d, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL p_wr_latency: got %0d required 4", lat); end
    @(negedge clk);
    checks++;
    if (last_nwe[1] !== 2) begin errors++; $display("FAIL p_nwe_len: got %0d required 2", last_nwe[1]); end
    do_vid(1'b1, 11'h000, d, lat);
    checks++;
    if (lat !== 5 || d !== 16'hFFFF) begin
      errors++; $display("FAIL p_rd: latency %0d data %h required 5 ffff", lat, d);
    end
    @(negedge clk);
    checks++;
    if (last_noe[1] !== 4) begin errors++; $display("FAIL p_noe_len: got %0d required 4", last_noe[1]); end
  endtask

  task automatic test_reset_mid_write;
    int n;
    cpu_we[0] = 1'b1; cpu_addr[0] = 11'h055; cpu_wdata[0] = 16'hBEEF; cpu_req[0] = 1'b1;
    n = 0;
    while (nwe[0] !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (nwe[0] !== 1'b0) begin errors++; $display("FAIL rstw_reach: nWE=%b required 0 (WPULSE)", nwe[0]); end
    rst = 1'b1; cpu_req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (cpu_ack[0] !== 1'b0) begin errors++; $display("FAIL rstw_ack%0d: CPU_ACK=%b required 0", i, cpu_ack[0]); end
    end
    check_idle_reset(1'b0, "rstw_in");
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset(1'b0, "rstw_after");
  endtask

  // Random overlapping traffic on instance 0 checked against a reference memory.
  task automatic test_random;
    int done, cyc;
    bit vp, cp, cw;
    logic [10:0] va, ca;
    logic [15:0] cd;
    for (int a = 0; a < 2048; a++) ref_mem[a] = mem[0][a];
    done = 0; cyc = 0; vp = 0; cp = 0; cw = 0; va = '0; ca = '0; cd = '0;
    while (done < 1000 && cyc < 20000) begin
      if (!vp && $urandom_range(0, 2) != 0) begin
        va = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1 ? 11'h7FF : 11'h000)
                                         : 11'($urandom_range(0, 15));
        vid_addr[0] = va; vid_req[0] = 1'b1; vp = 1;
      end
      if (!cp && $urandom_range(0, 2) != 0) begin
        ca = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) == 1 ? 11'h7FF : 11'h000)
                                         : 11'($urandom_range(0, 15));
        cw = $urandom_range(0, 1) == 1;
        cd = 16'($urandom);
        cpu_addr[0] = ca; cpu_we[0] = cw; cpu_wdata[0] = cd; cpu_req[0] = 1'b1; cp = 1;
      end
      @(negedge clk); cyc++;
      if (vid_ack[0]) begin
        checks++;
        if (!vp || vid_data[0] !== ref_mem[va]) begin
          errors++; $display("FAIL rnd_vid @%h: got %h required %h (pending=%0d)", va, vid_data[0], ref_mem[va], vp);
        end
        vp = 0; vid_req[0] = 1'b0; done++;
      end
      if (cpu_ack[0]) begin
        if (cw) ref_mem[ca] = cd;
        else begin
          checks++;
          if (!cp || cpu_rdata[0] !== ref_mem[ca]) begin
            errors++; $display("FAIL rnd_cpu @%h: got %h required %h (pending=%0d)", ca, cpu_rdata[0], ref_mem[ca], cp);
          end
        end
        cp = 0; cpu_req[0] = 1'b0; done++;
      end
    end
    vid_req[0] = 1'b0; cpu_req[0] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (done < 1000) begin errors++; $display("FAIL rnd_count: completed %0d required 1000", done); end
  endtask

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_g = 1'b0; pl_a = '0; pl_d = '0;
    for (int i = 0; i < 2; i++) begin
      vid_req[i] = 1'b0; vid_addr[i] = '0;
      cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
    end
    test_reset;
    test_write_read;
    test_video_read;
    test_alternate;
    test_params;
    test_reset_mid_write;
    test_random;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (viol[i] !== 0) begin errors++; $display("FAIL bus_invariants inst%0d: %0d violations required 0", i, viol[i]); end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fast_vram_ctrl.md
Name: fast_vram_ctrl

Overview:
- Synchronous access controller for the 2048-word x 16-bit fast VRAM pair (upper and lower 2K x 8, 35 ns asynchronous SRAMs).
- Drives the RAM's ADDR, DATA, nCE, nOE and nWE pins.
- Arbitrates between two requesters:
  - the video fetch port (fix/sprite attribute reads, read-only);
  - the CPU port (VRAM read/write registers).
- Sits between the LSPC logic and the fast VRAM chips. Converts request/ack handshakes into correctly timed SRAM strobe sequences.

Parameters:
- READ_WAIT, 1: extra cycles strobes stay active before read data is captured. Minimum 1, which gives 2 cycles of 41.7 ns, above 35 ns.
- WE_CYCLES, 1: number of cycles nWE is held low during a write. Minimum 1.

Ports:
- CLK  input  1  system clock (24 MHz)
- RESET  input  1  synchronous, active-high reset
- VID_REQ  input  1  video read request; held high until VID_ACK
- VID_ADDR  input  11  video read address
- VID_ACK  output  1  one-cycle pulse; VID_DATA valid in the same cycle
- VID_DATA  output  16  captured read word; holds until the next video capture
- CPU_REQ  input  1  CPU request; held high until CPU_ACK
- CPU_WE  input  1  1 = write, 0 = read; sampled at grant
- CPU_ADDR  input  11  CPU address; sampled at grant
- CPU_WDATA  input  16  CPU write data; sampled at grant
- CPU_ACK  output  1  one-cycle pulse; for reads, CPU_RDATA is valid in the same cycle
- CPU_RDATA  output  16  captured read word; holds until the next CPU read
- ADDR  output  11  RAM address (shared by both chips)
- DATA  inout  16  RAM data; [15:8] go to the upper chip, [7:0] to the lower chip
- nCE  output  1  RAM chip enable, active low
- nOE  output  1  RAM output enable, active low
- nWE  output  1  RAM write enable, active low

Behaviour:
- Synchronous active-high reset on RESET; one clock domain, CLK.
- All outputs are registered.
- Reset values:
  - nCE = nOE = nWE = 1; ADDR = 0; DATA released (Z).
  - VID_ACK = CPU_ACK = 0; VID_DATA = CPU_RDATA = 0.
  - State = IDLE; grant-priority flag = video.
- States: IDLE, RD, WSETUP, WPULSE, WHOLD.

Arbitration (IDLE only):
- Only one requester pending: grant it.
- Both pending: grant the one not granted most recently (strict alternation). After reset, video wins the first tie.
- The grant edge latches the address, and for CPU writes the write data, into internal registers. Requester inputs are ignored until the corresponding ACK.

RD (video read, or CPU read with CPU_WE = 0):
- At the grant edge: ADDR = granted address, nCE = 0, nOE = 0, nWE = 1, DATA released.
- Stays in RD for READ_WAIT+1 cycles.
- At the final edge:
  - DATA is captured into VID_DATA or CPU_RDATA;
  - the matching ACK is set for 1 cycle;
  - nCE = nOE = 1 and the state returns to IDLE.
- Latency with READ_WAIT = 1: ACK is high in the 3rd cycle after the cycle in which REQ was sampled at the grant edge (strobes low for 2 cycles).

Write (CPU_WE = 1):
- WSETUP, 1 cycle: nCE = 0, nOE = 1, nWE = 1, DATA driven with the latched word.
- WPULSE, WE_CYCLES cycles: nWE = 0, DATA still driven.
- WHOLD, 1 cycle: nWE = 1, nCE = 1, DATA still driven (hold time), CPU_ACK = 1.
- Then IDLE, with DATA released at that edge.

Bus invariants (assertion-checked):
- Never drive DATA while nOE = 0.
- Never have nOE = 0 and nWE = 0 at the same time.
- Never change ADDR while nCE = 0.
- nCE is 1 in IDLE.

Handshake and back-to-back:
- An ACK is exactly 1 cycle.
- A requester that keeps REQ high after ACK is treated as a new request at the next IDLE evaluation. IDLE lasts at least 1 cycle between accesses.

Reset mid-access:
- The access is aborted at the reset edge: strobes go high, DATA is released, no ACK is issued, capture registers are cleared.
- A write interrupted during WPULSE leaves the RAM contents undefined at that address. This is documented, not checked.

Width rules:
- Addresses are used as given, with no wrap logic. The 11-bit address covers exactly 0x000 to 0x7FF.

Test Plan:
- Reset with RESET held 3 cycles mid-write (state WPULSE) -> next cycle nCE = nOE = nWE = 1, DATA = Z, no CPU_ACK, VID_DATA = CPU_RDATA = 0000.
- CPU write 0x7FF <- A5C3, then CPU read 0x7FF -> nWE low exactly 1 cycle, CPU_RDATA = A5C3, each ACK 1 cycle wide, DATA never driven while nOE = 0.
- Preload the RAM model at 0x123 = 1234, video read 0x123 with READ_WAIT = 1 -> nCE/nOE low 2 cycles, VID_ACK 2 cycles after the grant edge with VID_DATA = 1234.
- VID_REQ and CPU_REQ rise together and are held continuously -> grants alternate V, C, V, C over 8 accesses, with IDLE at least 1 cycle between accesses.
- READ_WAIT = 3, WE_CYCLES = 2: CPU write 0x000 <- FFFF, video read 0x000 -> strobes low 4 cycles on the read, nWE low 2 cycles on the write, VID_DATA = FFFF.
- Random mix of 1000 requests against the RAM model with a reference memory -> all read data match, all bus invariants hold.
